mux_4_1_rr: RTL and testbench
=============================

// Module: mux_4_1_rr
// PURPOSE
//  4-to-1 collector; the return path of the 1x4 demux. Merges four valid/ready source lanes onto one
//  registered output stream. Tags each beat with the 2-bit index of its source lane (out_sel), so a
//  downstream demux_1_4 can re-route it.
//  Round-robin arbitration gives fair access. Sits between four per-lane producers and a shared sink.
// PARAMETERS
//  DW        8   data width per lane, in bits
// PORTS
//  clk        in   1      single clock; all logic on rising edge
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   4      per-lane request; bit k = lane k
//  in_data    in   4*DW   lane k data at [k*DW +: DW]
//  in_last    in   4      per-lane end-of-packet; used only with MUX41_PKT_LOCK_EN
//  in_ready   out  4      per-lane accept; one-hot or zero
//  out_valid  out  1      registered output beat valid
//  out_data   out  DW     registered output data
//  out_sel    out  2      source lane index of the current output beat
//  out_last   out  1      registered copy of the winning lane's in_last
//  out_ready  in   1      sink accepts when out_valid && out_ready
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_sel=2'd0, out_last=0, rr_ptr=2'd3.
//    in_ready is combinational and is 0 while rst_n=0.
//    Reset during a transfer drops the held beat. Any locked grant is released.
//  - load = !out_valid || out_ready. The output register accepts a new beat only when load=1.
//  - Arbitration:
//    - Among the lanes with in_valid=1, search (rr_ptr+1) mod 4, +2, +3, +4.
//    - The first match wins; that is grant, one-hot.
//    - in_ready = grant & {4{load}}, so at most one in_ready bit is set.
//  - Transfer on lane k (in_valid[k] && in_ready[k]):
//    - Next cycle: out_valid=1, out_data=in_data[k], out_sel=k, out_last=in_last[k].
//    - rr_ptr <= k.
//  - load=1 with no in_valid: out_valid <= 0, and out_data/out_sel/out_last hold their values.
//  - out_valid=1 && out_ready=0: all outputs are held stable, and in_ready=0.
//  - Latency is 1 cycle from input handshake to out_valid.
//    Throughput is 1 beat/cycle while out_ready=1 (sink accept and new load in the same cycle).
//  - A lane whose in_valid drops before it is granted loses its turn. There is no request memory.
//  - Width rules: out_sel and rr_ptr are 2-bit and wrap from 3 to 0. There is no arithmetic on data.
// CONFIGURATION
//  - MUX41_PKT_LOCK_EN defined:
//    - After lane k transfers a beat with in_last[k]=0, the grant stays locked on lane k.
//    - While locked, other lanes get in_ready=0, even if lane k is idle.
//    - The lock is released after the lane-k beat with in_last[k]=1 transfers, or on reset.
//    - rr_ptr advances only at release, so packets from different lanes are never interleaved.
//  - MUX41_PKT_LOCK_EN undefined:
//    - Arbitration runs per beat. in_last is passed through to out_last only; no lock state exists.
// STRUCTURE
//  - Package mux41_pkg: localparam int NUM_LANES=4; typedef logic [1:0] sel_t;
//    function automatic sel_t onehot2idx(logic [3:0]).
//  - Sub-module rr_arbiter_4:
//    - Inputs: req[3:0], ptr (sel_t).
//    - Outputs: grant[3:0] one-hot, grant_idx (sel_t).
//    - Purely combinational; instantiated once.
//  - Top level holds the output register, rr_ptr, lock flag/lane (under the macro) and the handshake logic.
// TESTING
//  - Reset: hold rst_n=0 for 2 cycles with all in_valid=1.
//    -> out_valid=0, out_sel=0, in_ready=0. First grant after release goes to lane 0.
//  - Single lane: in_valid=4'b0100, in_data lane2=8'hA5, out_ready=1.
//    -> next cycle out_valid=1, out_data=8'hA5, out_sel=2.
//  - Fairness: all in_valid=1, out_ready=1 for 8 cycles.
//    -> out_sel sequence is 0,1,2,3,0,1,2,3, with out_valid=1 on every cycle after the first.
//  - Backpressure: out_ready=0 for 3 cycles with a beat held.
//    -> out_data/out_sel are stable and in_ready=0. When out_ready returns to 1, the next lane in RR order loads.
//  - Sparse wrap: rr_ptr=3, in_valid=4'b1001 -> lane 0 granted. On the next request set 4'b1001 -> lane 3 granted.
//  - MUX41_PKT_LOCK_EN: lane1 sends 3 beats (in_last=0,0,1) while lane2 is valid throughout.
//    -> out_sel=1,1,1 then 2. Without the macro -> out_sel alternates 1,2,1,2.

Source files
------------

// File: rtl/mux_4_1_rr_pkg.sv
// Shared types and helpers for the 4-to-1 round-robin collector.
// The lock state type is used only when MUX41_PKT_LOCK_EN is defined.
package mux41_pkg;

   localparam int NUM_LANES = 4;

   typedef logic [1:0] sel_t;

   typedef enum logic {
      LOCK_IDLE,
      LOCK_HELD
   } lock_state_e;

   function automatic sel_t onehot2idx(logic [3:0] oh);
      sel_t idx;
      idx = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         if (oh[i]) idx = sel_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux_4_1_rr_if.sv
// Lane-side and sink-side handshake bundle of the 4-to-1 collector.
// The slave modport is the collector; the master modport is producers plus sink.
interface mux_4_1_rr_if #(
   parameter int unsigned DW = 8
);

   logic [3:0]        in_valid;
   logic [4*DW-1:0]   in_data;
   logic [3:0]        in_last;
   logic [3:0]        in_ready;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   mux41_pkg::sel_t   out_sel;
   logic              out_last;
   logic              out_ready;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_sel, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_sel, out_last
   );

endinterface

// File: rtl/mux_4_1_rr_arbiter.sv
// Combinational 4-way round-robin arbiter: searches ptr+1 .. ptr+4 (mod 4)
// and grants the first requesting lane.
module rr_arbiter_4
   import mux41_pkg::*;
(
   input  logic [3:0] req,
   input  sel_t       ptr,
   output logic [3:0] grant,
   output sel_t       grant_idx
);

   sel_t cand;

   always_comb begin
      grant = '0;
      cand  = '0;
      for (int unsigned off = 1; off <= NUM_LANES; off++) begin
         cand = ptr + sel_t'(off);
         if ((grant == '0) && req[cand]) grant[cand] = 1'b1;
      end
   end

   assign grant_idx = onehot2idx(grant);

endmodule

// File: rtl/mux_4_1_rr.sv
// 4-to-1 round-robin collector with a registered, lane-tagged output beat.
// Define MUX41_PKT_LOCK_EN to hold the grant on one lane until its in_last beat.
module mux_4_1_rr
   import mux41_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   mux_4_1_rr_if.slave       bus
);

   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q,  out_data_d;
   sel_t          out_sel_q,   out_sel_d;
   logic          out_last_q,  out_last_d;
   sel_t          rr_ptr_q,    rr_ptr_d;

   logic          load;
   logic [3:0]    req;
   logic [3:0]    grant;
   sel_t          grant_idx;
   logic          xfer;
   logic [DW-1:0] win_data;
   logic          win_last;

`ifdef MUX41_PKT_LOCK_EN
   lock_state_e   lock_q,      lock_d;
   sel_t          lock_lane_q, lock_lane_d;

   // While locked only the owning lane may request, even if it is idle.
   always_comb begin
      req = bus.in_valid;
      if (lock_q == LOCK_HELD) req = bus.in_valid & (4'b0001 << lock_lane_q);
   end
`else
   assign req = bus.in_valid;
`endif

   rr_arbiter_4 u_arb (
      .req       (req),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign load         = !out_valid_q || bus.out_ready;
   assign bus.in_ready = (rst_n && load) ? grant : '0;
   assign xfer         = |bus.in_ready;
   assign win_data     = bus.in_data[grant_idx*DW +: DW];
   assign win_last     = bus.in_last[grant_idx];

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_last_d  = out_last_q;
      rr_ptr_d    = rr_ptr_q;
`ifdef MUX41_PKT_LOCK_EN
      lock_d      = lock_q;
      lock_lane_d = lock_lane_q;
`endif
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = win_data;
         out_sel_d   = grant_idx;
         out_last_d  = win_last;
`ifdef MUX41_PKT_LOCK_EN
         // Pointer moves only when the packet ends, so packets never interleave.
         lock_lane_d = grant_idx;
         if (win_last) begin
            lock_d   = LOCK_IDLE;
            rr_ptr_d = grant_idx;
         end else begin
            lock_d   = LOCK_HELD;
         end
`else
         rr_ptr_d    = grant_idx;
`endif
      end else if (load) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_last_q  <= 1'b0;
         rr_ptr_q    <= 2'd3;
`ifdef MUX41_PKT_LOCK_EN
         lock_q      <= LOCK_IDLE;
         lock_lane_q <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_last_q  <= out_last_d;
         rr_ptr_q    <= rr_ptr_d;
`ifdef MUX41_PKT_LOCK_EN
         lock_q      <= lock_d;
         lock_lane_q <= lock_lane_d;
`endif
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;
   assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_mux_4_1_rr.sv
// Directed bench for mux_4_1_rr: per-cycle vector table plus a packet sequence
// whose expected lane order depends on MUX41_PKT_LOCK_EN.
module tb_mux_4_1_rr;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   mux_4_1_rr_if #(.DW(8)) bus ();

   mux_4_1_rr #(.DW(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  last;
      logic        ordy;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [7:0]  exp_od;
      logic [1:0]  exp_os;
      logic        exp_ol;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d,
                      input logic [3:0] l, input logic o, input logic [3:0] er,
                      input logic eov, input logic [7:0] eod, input logic [1:0] eos,
                      input logic eol);
      vec_t x;
      x.rst_n = r; x.valid = v; x.data = d; x.last = l; x.ordy = o;
      x.exp_rdy = er; x.exp_ov = eov; x.exp_od = eod; x.exp_os = eos; x.exp_ol = eol;
      vt.push_back(x);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   localparam logic [31:0] D  = 32'h13121110;
   localparam logic [31:0] DA = 32'h13A51110;

   logic [3:0]  rdy;
   logic [10:0] beats [4];
   logic [10:0] exp_beats [4];
   int          b;
   int          got;

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.in_last   = '0;
      bus.out_ready = 1'b1;

      //   rst valid   data last  ordy  rdy     ov  od     os    ol
      add(0, 4'hF, D,  4'hF, 1, 4'b0000, 0, 8'h00, 2'd0, 0);  // reset, all lanes requesting
      add(0, 4'hF, D,  4'hF, 1, 4'b0000, 0, 8'h00, 2'd0, 0);
      add(1, 4'hF, D,  4'hF, 1, 4'b0001, 1, 8'h10, 2'd0, 1);  // fairness 0,1,2,3,0,1,2,3
      add(1, 4'hF, D,  4'hF, 1, 4'b0010, 1, 8'h11, 2'd1, 1);
      add(1, 4'hF, D,  4'hF, 1, 4'b0100, 1, 8'h12, 2'd2, 1);
      add(1, 4'hF, D,  4'hF, 1, 4'b1000, 1, 8'h13, 2'd3, 1);
      add(1, 4'hF, D,  4'hF, 1, 4'b0001, 1, 8'h10, 2'd0, 1);
      add(1, 4'hF, D,  4'hF, 1, 4'b0010, 1, 8'h11, 2'd1, 1);
      add(1, 4'hF, D,  4'hF, 1, 4'b0100, 1, 8'h12, 2'd2, 1);
      add(1, 4'hF, D,  4'hF, 1, 4'b1000, 1, 8'h13, 2'd3, 1);
      add(1, 4'h0, D,  4'hF, 1, 4'b0000, 0, 8'h13, 2'd3, 1);  // idle: fields hold
      add(1, 4'h4, DA, 4'hF, 1, 4'b0100, 1, 8'hA5, 2'd2, 1);  // single lane 2
      add(1, 4'hF, D,  4'hF, 0, 4'b0000, 1, 8'hA5, 2'd2, 1);  // backpressure x3
      add(1, 4'hF, D,  4'hF, 0, 4'b0000, 1, 8'hA5, 2'd2, 1);
      add(1, 4'hF, D,  4'hF, 0, 4'b0000, 1, 8'hA5, 2'd2, 1);
      add(1, 4'hF, D,  4'hF, 1, 4'b1000, 1, 8'h13, 2'd3, 1);  // next in RR order after 2
      add(1, 4'h9, D,  4'hF, 1, 4'b0001, 1, 8'h10, 2'd0, 1);  // sparse wrap from ptr 3
      add(1, 4'h9, D,  4'hF, 1, 4'b1000, 1, 8'h13, 2'd3, 1);
      add(1, 4'h0, D,  4'hF, 1, 4'b0000, 0, 8'h13, 2'd3, 1);
      add(1, 4'h2, D,  4'hF, 0, 4'b0010, 1, 8'h11, 2'd1, 1);  // empty output loads despite ordy=0
      add(1, 4'h2, D,  4'hF, 0, 4'b0000, 1, 8'h11, 2'd1, 1);
      add(1, 4'h0, D,  4'hF, 1, 4'b0000, 0, 8'h11, 2'd1, 1);
      add(1, 4'h4, D,  4'hF, 1, 4'b0100, 1, 8'h12, 2'd2, 1);
      add(0, 4'hF, D,  4'hF, 0, 4'b0000, 0, 8'h00, 2'd0, 0);  // reset drops held beat
      add(1, 4'hF, D,  4'hF, 1, 4'b0001, 1, 8'h10, 2'd0, 1);

      foreach (vt[i]) begin
         @(negedge clk);
         rst_n         = vt[i].rst_n;
         bus.in_valid  = vt[i].valid;
         bus.in_data   = vt[i].data;
         bus.in_last   = vt[i].last;
         bus.out_ready = vt[i].ordy;
         #1;
         chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vt[i].exp_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_out{v,d,s,l}", i),
             32'({bus.out_valid, bus.out_data, bus.out_sel, bus.out_last}),
             32'({vt[i].exp_ov, vt[i].exp_od, vt[i].exp_os, vt[i].exp_ol}));
      end

      // Packet sequence: lane 1 sends 3 beats (last on the third), lane 2 always valid.
      @(negedge clk);
      bus.in_valid  = '0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      b   = 0;
      got = 0;
      for (int i = 0; i < 4; i++) beats[i] = '0;
`ifdef MUX41_PKT_LOCK_EN
      exp_beats[0] = {2'd1, 8'h20, 1'b0};
      exp_beats[1] = {2'd1, 8'h21, 1'b0};
      exp_beats[2] = {2'd1, 8'h22, 1'b1};
      exp_beats[3] = {2'd2, 8'h30, 1'b1};
`else
      exp_beats[0] = {2'd1, 8'h20, 1'b0};
      exp_beats[1] = {2'd2, 8'h30, 1'b1};
      exp_beats[2] = {2'd1, 8'h21, 1'b0};
      exp_beats[3] = {2'd2, 8'h30, 1'b1};
`endif
      for (int cyc = 0; cyc < 12 && got < 4; cyc++) begin
         @(negedge clk);
         bus.in_valid = {1'b0, 1'b1, (b < 3), 1'b0};
         bus.in_data  = {8'h00, 8'h30, 8'(32'h20 + b), 8'h00};
         bus.in_last  = {1'b0, 1'b1, (b == 2), 1'b0};
         #1;
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         if (rdy[1]) b++;
         if (bus.out_valid) begin
            beats[got] = {bus.out_sel, bus.out_data, bus.out_last};
            got++;
         end
      end
      chk("pkt_beat_count", 32'(got), 32'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("pkt_beat%0d{s,d,l}", i), 32'(beats[i]), 32'(exp_beats[i]));

      @(negedge clk);
      bus.in_valid = '0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
